// File: rtl/vc_iter_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit with val/rdy handshakes and a latched domain label.
// Optional signed operation (in_signed port) is enabled by defining VC_MULDIV_SIGNED_EN.
module vc_iter_muldiv #(
    parameter int unsigned p_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   domain,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic                   in_fn,
    input  logic [p_nbits-1:0]     in0,
    input  logic [p_nbits-1:0]     in1,
`ifdef VC_MULDIV_SIGNED_EN
    input  logic                   in_signed,
`endif
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic                   out_domain,
    output logic [2*p_nbits-1:0]   out
);

    localparam int unsigned N  = p_nbits;
    localparam int unsigned W2 = 2 * p_nbits;
    localparam int unsigned CW = $clog2(p_nbits) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    rem_q, rem_d;   // div: partial remainder; mul: upper product half
    logic [N-1:0]  lo_q, lo_d;     // div: dividend/quotient; mul: multiplier/lower half
    logic [N-1:0]  b_q, b_d;
    logic          fn_q, fn_d;
    logic          dom_q, dom_d;
    logic [W2-1:0] out_q, out_d;
    logic          in_rdy_q, in_rdy_d;
    logic          out_val_q, out_val_d;
`ifdef VC_MULDIV_SIGNED_EN
    logic          neg_q, neg_d;
    logic          rneg_q, rneg_d;
    logic          a_neg, b_neg;
    logic [N-1:0]  quo_s, rem_s;
`endif

    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    mul_sum;
    logic [N:0]    div_trial;
    logic [N+1:0]  div_sub;
    logic [N:0]    step_rem;
    logic [N-1:0]  step_lo;
    logic [W2-1:0] res;

    // Next-state, datapath step and result formatting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        lo_d      = lo_q;
        b_d       = b_q;
        fn_d      = fn_q;
        dom_d     = dom_q;
        out_d     = out_q;
`ifdef VC_MULDIV_SIGNED_EN
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        a_neg     = in_signed & in0[N-1];
        b_neg     = in_signed & in1[N-1];
        a_mag     = a_neg ? N'(-in0) : in0;
        b_mag     = b_neg ? N'(-in1) : in1;
        quo_s     = '0;
        rem_s     = '0;
`else
        a_mag     = in0;
        b_mag     = in1;
`endif

        // One shift-add (mul) or restoring shift-subtract (div) step
        mul_sum   = {1'b0, rem_q[N-1:0]} + ({1'b0, b_q} & {(N+1){lo_q[0]}});
        div_trial = {rem_q[N-1:0], lo_q[N-1]};
        div_sub   = {1'b0, div_trial} - {2'b00, b_q};
        if (fn_q) begin
            if (!div_sub[N+1]) begin
                step_rem = div_sub[N:0];
                step_lo  = {lo_q[N-2:0], 1'b1};
            end else begin
                step_rem = div_trial;
                step_lo  = {lo_q[N-2:0], 1'b0};
            end
        end else begin
            step_rem = {1'b0, mul_sum[N:1]};
            step_lo  = {mul_sum[0], lo_q[N-1:1]};
        end

        res = {step_rem[N-1:0], step_lo};
`ifdef VC_MULDIV_SIGNED_EN
        if (fn_q) begin
            quo_s = neg_q  ? N'(-step_lo) : step_lo;
            rem_s = rneg_q ? N'(-step_rem[N-1:0]) : step_rem[N-1:0];
            res   = {rem_s, quo_s};
        end else if (neg_q) begin
            res   = W2'(-res);
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (in_val) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    lo_d    = a_mag;
                    b_d     = b_mag;
                    fn_d    = in_fn;
                    dom_d   = domain;
`ifdef VC_MULDIV_SIGNED_EN
                    // Div-by-zero keeps the all-ones quotient unsigned; rem sign restores in0
                    neg_d   = (a_neg ^ b_neg) & ~(in_fn & (in1 == '0));
                    rneg_d  = a_neg & in_fn;
`endif
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    out_d   = res;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_rdy_d  = (state_d == S_IDLE);
        out_val_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            fn_q      <= 1'b0;
            dom_q     <= 1'b0;
            out_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
`ifdef VC_MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            fn_q      <= fn_d;
            dom_q     <= dom_d;
            out_q     <= out_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
`ifdef VC_MULDIV_SIGNED_EN
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign in_rdy     = in_rdy_q;
    assign out_val    = out_val_q;
    assign out_domain = dom_q;
    assign out        = out_q;

endmodule
